uart_mmio: RTL and testbench

Memory-mapped front end for the UART peripheral. It sits between the core's peripheral bus and the UART byte-stream ports. It buffers transmit bytes in a TX FIFO that feeds the UART `din` handshake, and received bytes in an RX FIFO filled from the UART `dout` handshake. Software sees data, status and control registers and a level interrupt.

---
 rtl/uart_mmio.sv | 196 +++++++++++++++++++
 tb/tb_uart_mmio.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX/RX byte FIFOs behind DATA/STATUS/CTRL registers plus a level irq.
// Latency: bus response 1 cycle after acceptance; bus write reaches tx_valid 1 cycle after acceptance.
// Backpressure: one outstanding bus request (req_ready = !rsp_valid); rx_ready drops when RX FIFO is full.

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module uart_mmio #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [3:0]           req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 irq
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_t;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_count;
        logic [7:0] tx_count;
        logic [2:0] rsvd_lo;
        logic       tx_drop;
        logic       rx_full;
        logic       rx_empty;
        logic       tx_empty;
        logic       tx_full;
    } status_t;

    logic                 acc;
    reg_sel_t             sel;
    logic                 data_wr;
    logic                 data_rd;
    logic                 tx_full;
    logic                 tx_empty;
    logic [TCW-1:0]       tx_count;
    logic                 rx_full;
    logic                 rx_empty;
    logic [RCW-1:0]       rx_count;
    logic [DATA_BITS-1:0] rx_head;
    logic [2:0]           ctrl;
    logic                 tx_drop;
    status_t              status;
    logic [31:0]          rd_mux;
    logic                 unused_ok;

    assign req_ready = !rsp_valid;
    assign acc       = req_valid && req_ready;
    assign sel       = reg_sel_t'(req_addr[3:2]);
    assign data_wr   = acc && req_we && (sel == REG_DATA);
    assign data_rd   = acc && !req_we && (sel == REG_DATA);
    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_full;
    assign unused_ok = ^{req_addr[1:0], req_wdata};

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (data_wr),
        .wr_dat (req_wdata[DATA_BITS-1:0]),
        .rd_rdy (tx_ready),
        .rd_dat (tx_data),
        .count  (tx_count),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    // RX pushes are gated by rx_ready inside the FIFO, so nothing received is ever lost.
    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rx_valid),
        .wr_dat (rx_data),
        .rd_rdy (data_rd),
        .rd_dat (rx_head),
        .count  (rx_count),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_comb begin
        status          = '0;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.rx_empty = rx_empty;
        status.rx_full  = rx_full;
        status.tx_drop  = tx_drop;
        status.tx_count = 8'(tx_count);
        status.rx_count = 8'(rx_count);
        rd_mux          = '0;
        if (!req_we) begin
            unique case (sel)
                REG_DATA:   if (!rx_empty) rd_mux = {1'b1, 23'b0, 8'(rx_head)};
                REG_STATUS: rd_mux = status;
                REG_CTRL:   rd_mux = {29'b0, ctrl};
                REG_RSVD:   rd_mux = '0;
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (acc) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_mux;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            tx_drop <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (acc && req_we && (sel == REG_CTRL)) ctrl <= req_wdata[2:0];
            if (data_wr && tx_full) begin
                tx_drop <= 1'b1;
            end else if (acc && req_we && (sel == REG_STATUS) && req_wdata[4]) begin
                tx_drop <= 1'b0;
            end
            irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty) || (ctrl[2] && tx_drop);
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed and randomized bench for uart_mmio, checked against a queue-based model of the register map.
module tb_uart_mmio;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    always #5 clk = ~clk;

    uart_mmio #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .irq       (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFOs as queues, registers as plain variables.
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       drop;
    logic [2:0] ctrl;
    logic       irq_exp;
    logic [31:0] hold_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic irq_fn();
        return (ctrl[0] && rx_q.size() > 0) || (ctrl[1] && tx_q.size() == 0) || (ctrl[2] && drop);
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (tx_q.size() == 16);
        s[1]     = (tx_q.size() == 0);
        s[2]     = (rx_q.size() == 0);
        s[3]     = (rx_q.size() == 16);
        s[4]     = drop;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        drop    = 1'b0;
        ctrl    = 3'b0;
        irq_exp = 1'b0;
    endtask

    // Every clock edge goes through here so the irq expectation follows the pre-edge model state.
    task automatic step_edge();
        @(posedge clk);
        #1;
        irq_exp   = irq_fn();
        req_valid = 1'b0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
    endtask

    task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] d, input logic txp);
        logic [31:0] exp;
        int          txn;
        step_edge();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tx_ready  = txp;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'h1);
        if (txp && tx_q.size() > 0) chk("tx_data_with_bus", 32'(tx_data), 32'(tx_q[0]));
        exp = 32'h0;
        if (!we) begin
            case (a[3:2])
                2'd0:    if (rx_q.size() > 0) exp = {1'b1, 23'b0, rx_q[0]};
                2'd1:    exp = status_exp();
                2'd2:    exp = {29'b0, ctrl};
                default: exp = 32'h0;
            endcase
        end
        txn = tx_q.size();
        step_edge();
        if (we) begin
            case (a[3:2])
                2'd0: if (txn == 16) drop = 1'b1; else tx_q.push_back(d[7:0]);
                2'd1: if (d[4]) drop = 1'b0;
                2'd2: ctrl = d[2:0];
                default: ;
            endcase
        end else if (a[3:2] == 2'd0 && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
        end
        if (txp && txn > 0) void'(tx_q.pop_front());
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk($sformatf("rdata_%s_a%0h", we ? "wr" : "rd", a), rsp_rdata, exp);
        chk("irq_after_bus", 32'(irq), 32'(irq_exp));
    endtask

    task automatic uart_cycle(input logic rxv, input logic [7:0] rxd, input logic txr);
        int rxn;
        int txn;
        step_edge();
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        @(negedge clk);
        chk("rx_ready", 32'(rx_ready), 32'(rx_q.size() < 16));
        chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
        if (tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
        rxn = rx_q.size();
        txn = tx_q.size();
        step_edge();
        if (rxv && rxn < 16) rx_q.push_back(rxd);
        if (txr && txn > 0) void'(tx_q.pop_front());
        @(negedge clk);
        chk("irq_after_uart", 32'(irq), 32'(irq_exp));
    endtask

    task automatic tx_drain(input int n);
        step_edge();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("drain_tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
            if (tx_q.size() > 0) chk("drain_tx_data", 32'(tx_data), 32'(tx_q[0]));
            step_edge();
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            if (i < n - 1) tx_ready = 1'b1;
        end
        @(negedge clk);
        chk("drain_end_tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
        chk("irq_after_drain", 32'(irq), 32'(irq_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step_edge();
            @(negedge clk);
            chk("irq_idle", 32'(irq), 32'(irq_exp));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        tx_ready  = 1'b0;
        rx_data   = 8'h0;
        rx_valid  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_rx_ready", 32'(rx_ready), 32'h1);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        bus(1'b0, 4'h4, 32'h0, 1'b0);

        // Two TX bytes held back, then drained on consecutive cycles.
        bus(1'b1, 4'h0, 32'h41, 1'b0);
        bus(1'b1, 4'h0, 32'h42, 1'b0);
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        tx_drain(2);
        bus(1'b0, 4'h4, 32'h0, 1'b0);

        // TX overflow, sticky drop, clear, and drop despite a same-cycle UART pop.
        for (int i = 0; i < 16; i++) bus(1'b1, 4'h0, $urandom, 1'b0);
        bus(1'b1, 4'h0, 32'h55, 1'b0);
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        bus(1'b1, 4'h4, 32'h10, 1'b0);
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        tx_drain(1);
        bus(1'b1, 4'h0, 32'h66, 1'b0);
        bus(1'b1, 4'h0, 32'h55, 1'b1);
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        bus(1'b1, 4'h4, 32'h10, 1'b0);
        tx_drain(17);

        // RX fill to the brim, a stalled 17th byte, then read everything back.
        for (int i = 0; i < 16; i++) uart_cycle(1'b1, 8'(i), 1'b0);
        uart_cycle(1'b1, 8'h10, 1'b0);
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) bus(1'b0, 4'h0, 32'h0, 1'b0);

        // RX interrupt rises after a push and falls after the read.
        bus(1'b1, 4'h8, 32'h1, 1'b0);
        bus(1'b0, 4'h8, 32'h0, 1'b0);
        uart_cycle(1'b1, 8'hA5, 1'b0);
        idle(2);
        bus(1'b0, 4'h0, 32'h0, 1'b0);
        idle(2);

        // Randomized traffic over every register and both UART sides.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 11))
                0, 1:    bus(1'b1, {2'd0, 2'($urandom)}, $urandom, 1'b0);
                2, 3:    bus(1'b0, {2'd0, 2'($urandom)}, $urandom, 1'b0);
                4:       bus(1'b0, {2'd1, 2'($urandom)}, $urandom, 1'b0);
                5:       bus(1'b1, {2'd1, 2'($urandom)}, $urandom, 1'b0);
                6:       bus(1'($urandom), {2'd2, 2'($urandom)}, $urandom, 1'b0);
                7, 8:    uart_cycle(1'b1, 8'($urandom), 1'($urandom));
                9:       tx_drain($urandom_range(1, 4));
                10:      bus(1'($urandom), {2'd3, 2'($urandom)}, $urandom, 1'($urandom));
                default: bus(1'b1, 4'h0, $urandom, 1'b1);
            endcase
        end

        // Response held off for 5 cycles, then a reset discards it and all FIFO contents.
        bus(1'b1, 4'h0, 32'h77, 1'b0);
        uart_cycle(1'b1, 8'h3C, 1'b0);
        bus(1'b1, 4'h8, 32'h7, 1'b0);
        step_edge();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h4;
        req_wdata = 32'h0;
        hold_exp  = status_exp();
        step_edge();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
            chk("hold_rsp_rdata", rsp_rdata, hold_exp);
            step_edge();
        end
        rst = 1'b1;
        step_edge();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h1);
        chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'h1);
        chk("midrst_irq", 32'(irq), 32'h0);
        rsp_ready = 1'b1;
        bus(1'b0, 4'h4, 32'h0, 1'b0);
        bus(1'b0, 4'h0, 32'h0, 1'b0);
        bus(1'b0, 4'h8, 32'h0, 1'b0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
